// File: rtl/jb_p2s_sched.sv
// jb_p2s_sched: round-robin owner of one shared start-on-edge p2s burst counter.
// Optional per-requester burst statistics are built when JB_P2S_SCHED_STATS_EN is defined.
`timescale 1ns/1ps
module jb_p2s_sched #(
   parameter int NUM_REQ     = 4,
   parameter int COUNT_WIDTH = 39,
   parameter int GAP_WIDTH   = 8
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           sched_en,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*COUNT_WIDTH-1:0] len,
   input  logic [GAP_WIDTH-1:0]           cfg_gap,
   input  logic                           stat_clr,
   output logic [NUM_REQ-1:0]             grant,
   output logic [NUM_REQ-1:0]             done,
   output logic                           p2s_enable,
   output logic [COUNT_WIDTH-1:0]         p2s_max_value,
   output logic                           busy,
   output logic [NUM_REQ*16-1:0]          stat_bursts
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [GAP_WIDTH-1:0]   GAP_ONE   = {{(GAP_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0]       PTR_LAST  = PTR_W'(NUM_REQ - 1);
   localparam logic [PTR_W:0]         NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t                   state_r,     state_s;
   logic [PTR_W-1:0]         ptr_r,       ptr_s;
   logic [COUNT_WIDTH-1:0]   mirror_r,    mirror_s;
   logic [GAP_WIDTH-1:0]     gap_cnt_r,   gap_cnt_s;
   logic [NUM_REQ-1:0]       grant_r,     grant_s;
   logic [NUM_REQ-1:0]       done_r,      done_s;
   logic                     enable_r,    enable_s;
   logic [COUNT_WIDTH-1:0]   max_r,       max_s;
   logic                     busy_r,      busy_s;

   logic                     found_s;
   logic [PTR_W-1:0]         sel_s;
   logic [PTR_W:0]           idx_s;
   logic [COUNT_WIDTH-1:0]   sel_len_s;

   // Round-robin search for the first requester after the previous owner
   always_comb begin
      found_s   = 1'b0;
      sel_s     = ptr_r;
      sel_len_s = '0;
      idx_s     = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx_s = {1'b0, ptr_r} + (PTR_W+1)'(i);
         if (idx_s >= NUM_REQ_W) begin
            idx_s = idx_s - NUM_REQ_W;
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && req[idx_s[PTR_W-1:0]]) begin
            found_s   = 1'b1;
            sel_s     = idx_s[PTR_W-1:0];
            sel_len_s = len[int'(idx_s[PTR_W-1:0])*COUNT_WIDTH +: COUNT_WIDTH];
         end else begin
            found_s   = found_s;
         end
      end
   end

   // Next-state and next-output decode for IDLE/RUN/GAP
   always_comb begin
      state_s   = state_r;
      ptr_s     = ptr_r;
      mirror_s  = mirror_r;
      gap_cnt_s = gap_cnt_r;
      grant_s   = grant_r;
      done_s    = '0;
      enable_s  = 1'b0;
      max_s     = max_r;
      case (state_r)
         ST_IDLE: begin
            // A done pulse in flight means the requester has not yet dropped req
            if (sched_en && found_s && (done_r == '0)) begin
               ptr_s = sel_s;
               if (sel_len_s != '0) begin
                  state_s        = ST_RUN;
                  grant_s        = '0;
                  grant_s[sel_s] = 1'b1;
                  enable_s       = 1'b1;
                  max_s          = sel_len_s;
                  mirror_s       = sel_len_s;
               end else begin
                  done_s[sel_s]  = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (done_r != '0) begin
               grant_s = '0;
               if (cfg_gap != '0) begin
                  state_s   = ST_GAP;
                  gap_cnt_s = cfg_gap;
               end else begin
                  state_s   = ST_IDLE;
               end
            end else begin
               // Mirror holds through the start-pulse cycle, then tracks the counter
               if (enable_r) begin
                  mirror_s = mirror_r;
               end else begin
                  mirror_s = mirror_r - CNT_ONE;
               end
               if (mirror_s == CNT_ONE) begin
                  done_s = grant_r;
               end else begin
                  done_s = '0;
               end
            end
         end
         ST_GAP: begin
            grant_s = '0;
            if (gap_cnt_r <= GAP_ONE) begin
               state_s   = ST_IDLE;
            end else begin
               gap_cnt_s = gap_cnt_r - GAP_ONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            grant_s = '0;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State, pointer and registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r   <= ST_IDLE;
         ptr_r     <= PTR_LAST;
         mirror_r  <= '0;
         gap_cnt_r <= '0;
         grant_r   <= '0;
         done_r    <= '0;
         enable_r  <= 1'b0;
         max_r     <= '0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         ptr_r     <= ptr_s;
         mirror_r  <= mirror_s;
         gap_cnt_r <= gap_cnt_s;
         grant_r   <= grant_s;
         done_r    <= done_s;
         enable_r  <= enable_s;
         max_r     <= max_s;
         busy_r    <= busy_s;
      end
   end

   assign grant         = grant_r;
   assign done          = done_r;
   assign p2s_enable    = enable_r;
   assign p2s_max_value = max_r;
   assign busy          = busy_r;

`ifdef JB_P2S_SCHED_STATS_EN
   logic [NUM_REQ*16-1:0] stat_r;

   // Saturating per-requester burst counters; only real bursts carry a grant with done
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_r <= '0;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (stat_clr) begin
               stat_r[k*16 +: 16] <= 16'h0000;
            end else if (done_r[k] && grant_r[k] && (stat_r[k*16 +: 16] != 16'hFFFF)) begin
               stat_r[k*16 +: 16] <= stat_r[k*16 +: 16] + 16'h0001;
            end else begin
               stat_r[k*16 +: 16] <= stat_r[k*16 +: 16];
            end
         end
      end
   end

   assign stat_bursts = stat_r;
`else
   logic unused_stat_clr_s;

   assign unused_stat_clr_s = stat_clr;
   assign stat_bursts       = '0;
`endif

endmodule

// File: doc/jb_p2s_sched.md
# jb_p2s_sched

Round-robin scheduler that shares one parallel-to-serial burst counter (start-on-rising-edge, counts 1..max_value then returns to 0) between several UL DFE requesters. Each requester posts a burst length; the scheduler grants one requester at a time, programs the counter's max value, and issues the start edge. It tracks burst progress with an internal mirror counter, pulses a per-requester done, and inserts a programmable idle gap between bursts. It sits between the per-carrier UL DFE request logic and the shared p2s counter instance.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- COUNT_WIDTH, 39, burst length / counter width; must match the shared counter
- GAP_WIDTH, 8, width of inter-burst gap field
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- sched_en  in  1  permits new arbitration; does not abort a running burst
- req  in  NUM_REQ  level request per requester; held until its done
- len  in  NUM_REQ*COUNT_WIDTH  burst length per requester, slice k = len[k*COUNT_WIDTH +: COUNT_WIDTH]
- cfg_gap  in  GAP_WIDTH  idle cycles inserted after each burst
- stat_clr  in  1  clears statistics counters (see Configuration)
- grant  out  NUM_REQ  one-hot owner of the running burst, else 0
- done  out  NUM_REQ  one-cycle pulse at burst end (or zero-length acknowledge)
- p2s_enable  out  1  one-cycle start pulse to the shared counter's enable
- p2s_max_value  out  COUNT_WIDTH  burst length to the shared counter
- busy  out  1  high in RUN and GAP
- stat_bursts  out  NUM_REQ*16  per-requester burst count

## Operation
- States: IDLE, RUN, GAP. Reset: IDLE, all outputs 0, RR pointer = NUM_REQ-1 (requester 0 wins first).
- IDLE: when sched_en=1 and |req, select the first requester k with req[k]=1, searching upward from pointer+1 modulo NUM_REQ. Register the decision; pointer <= k.
  - len[k] != 0: next cycle grant=onehot(k), p2s_enable=1, p2s_max_value=len[k] (captured; stable until the next grant), mirror <= len[k], state RUN.
  - len[k] == 0: next cycle done[k]=1, no grant, no p2s_enable, stay IDLE. A zero max value never reaches the counter.
- RUN: p2s_enable=0. Mirror decrements each cycle starting the cycle after the start pulse. When mirror reaches 1, done[k]=1 that cycle. grant is cleared on the following cycle. Next state is GAP if cfg_gap!=0, else IDLE.
- GAP: count cfg_gap cycles (sampled on entry), then go to IDLE. grant=0.
- req and len are sampled only in IDLE; changes during RUN/GAP are ignored. req dropping before done does not abort the burst.
- sched_en=0 during RUN/GAP: the burst and gap complete; no new arbitration occurs.
- Mirror width is COUNT_WIDTH; no wrap, since len >= 1 in RUN.

## Timing
- Request visible in IDLE at cycle T → grant and p2s_enable at T+1 → shared counter = 1 at T+2 → counter = L and done[k] at T+1+L. grant is high T+1..T+1+L inclusive.
- Counter returns to 0 at T+2+L. With cfg_gap=0, the earliest re-arbitration is T+2+L and the next start pulse is T+3+L. p2s_enable is therefore low for at least 1 cycle between pulses, which guarantees a rising edge.
- With cfg_gap=G, GAP occupies T+2+L..T+1+L+G and the next arbitration is at T+2+L+G.
- Requesters deassert req in the cycle after done (registered response). The scheduler does not arbitrate in the done cycle.
- Reset asserted mid-burst: all outputs go to 0 asynchronously. The shared counter is reset by the same resetn.

## Configuration
- JB_P2S_SCHED_STATS_EN defined: stat_bursts slice k is a 16-bit saturating counter.
  - Increments on each done[k] from a non-zero-length burst.
  - stat_clr clears all counters synchronously; stat_clr has priority over an increment in the same cycle.
- Not defined: stat_bursts tied to 0, stat_clr ignored, no counter registers.

## Test plan
- Single requester, len[0]=5, cfg_gap=0, req at T: grant=0001 and p2s_enable at T+1; done[0] at T+6; shared counter runs 1..5; busy drops at T+7.
- All four requesting continuously, len=3, cfg_gap=2: grants in order 0,1,2,3,0, with start pulses spaced 3+1+2+1=7 cycles apart.
- len[2]=0 with req[2] only: done[2] pulses at T+1; p2s_enable and grant stay 0; the counter stays 0.
- sched_en dropped mid-burst with req[1] pending: the current burst finishes with done; no further grant until sched_en returns.
- resetn pulsed low mid-RUN: grant, p2s_enable, done and busy go to 0 immediately. After release, requester 0 is served first.
- Stats build: 3 bursts on requester 1 gives stat_bursts[31:16]=3; stat_clr returns it to 0. Non-stats build: always 0.
